sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 core.
- Accepts a message as a byte stream with its byte length announced up front.
- Applies FIPS 180-4 padding: 0x80 byte, zero fill, then the 64-bit big-endian bit length.
- Emits padded 512-bit blocks over a valid/ready handshake, plus the total block count that the core needs for its N input.

Parameters:
- LEN_W, 14, width of the message byte-length input. Maximum accepted length is 16311 bytes, so N ≤ 255.
- N_W, 8, width of the block-count output. Matches the core's N input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a message. Sampled only in IDLE.
- i_len  in  LEN_W  message length in bytes. Sampled with i_start.
- o_busy  out  1  high from the cycle after an accepted start until the last block handshake completes.
- o_err  out  1  one-cycle pulse when a start is rejected because the computed N exceeds 255.
- o_n_blocks  out  N_W  block count, N = floor((len+8)/64)+1. Registered at the accepted start and held until the next accepted start.
- i_byte_valid  in  1  message byte valid.
- i_byte  in  8  message byte, in order, first byte first.
- o_byte_ready  out  1  padder can accept a byte this cycle.
- o_blk_valid  out  1  padded block available.
- o_blk  out  512  padded block. Byte k of the block occupies bits [511-8k : 504-8k].
- o_blk_last  out  1  qualifies o_blk_valid; marks the final block of the message.
- i_blk_ready  in  1  downstream accepts the block.

Behaviour:
- Reset values: o_busy=0, o_err=0, o_n_blocks=0, o_byte_ready=0, o_blk_valid=0, o_blk=0, o_blk_last=0. State returns to IDLE and the internal buffer, pointer, remaining count and flags clear.
- Reset takes effect mid-message from any state. A partially emitted message is abandoned; no further blocks are emitted.
- State IDLE:
  - On i_start, compute N with at least 9-bit arithmetic.
  - If N>255: pulse o_err next cycle and stay in IDLE.
  - Otherwise go to ABSORB with ptr=0, rem=i_len, pad80=0, and latch bitlen = i_len×8 zero-extended to 64 bits.
- State ABSORB:
  - o_byte_ready = (rem≠0) and (ptr<64), as a combinational function of registered state.
  - On valid&ready: buf[ptr]=i_byte, ptr+1, rem−1.
  - If ptr reaches 64, go to EMIT with last=0.
  - If rem=0 and ptr<64, go to PAD. This includes entering ABSORB with rem=0.
- State PAD takes exactly 1 cycle:
  - If pad80=0: write buf[ptr]=0x80, set pad80=1, ptr+1.
  - Zero all bytes from ptr to 63.
  - If the post-0x80 ptr ≤ 56: bytes 56..63 = bitlen, big-endian, and last=1.
  - Otherwise last=0.
  - Go to EMIT.
- State EMIT:
  - o_blk_valid=1. o_blk and o_blk_last are held stable until i_blk_ready=1.
  - On handshake, if last: go to IDLE with o_busy=0 the next cycle.
  - Otherwise: clear buffer, ptr=0, then go to ABSORB if rem≠0, else to PAD.
  - A follow-on PAD with pad80=1 produces a block that is zero except bytes 56..63 = bitlen.
- Message ending exactly on a 64-byte boundary: the full block is emitted non-last. The next block is 0x80, zeros, then length.
- Latency:
  - A full block is valid the cycle after its 64th byte is accepted.
  - A padded block is valid 2 cycles after the final byte is accepted (ABSORB→PAD→EMIT).
- The number of blocks emitted always equals o_n_blocks.
- i_start is ignored while o_busy=1. i_byte_valid is ignored whenever o_byte_ready=0.
- o_err and an accepted start are mutually exclusive.

Test Plan:
- len=3, bytes 61 62 63 → one block 0x6162638000…0018, o_blk_last=1, o_n_blocks=1. Feeding it to the core yields ba7816bf…f20015ad.
- len=0 → o_n_blocks=1, block = 0x80 followed by zeros, length field 0, last=1; valid 2 cycles after start.
- len=55 → N=1, 0x80 at byte 55, length 0x1B8. len=56 → N=2: block0 has 0x80 at byte 56 and last=0; block1 is zeros plus 0x1C0 and last=1.
- len=64 → N=2: block0 is the raw data with last=0; block1 is 0x80, zeros, 0x200, last=1. Hold i_blk_ready=0 for 5 cycles: o_blk stays stable and no bytes are accepted.
- i_len=16312 → o_err pulses for 1 cycle, o_busy stays 0, o_n_blocks unchanged. i_len=16311 → accepted, N=255.
- Assert rst during ABSORB of a 100-byte message → next cycle all outputs are 0 and the state is IDLE. A new "abc" start then produces the correct single block.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: absorbs a byte stream of announced length and emits
// FIPS 180-4 padded 512-bit blocks plus the block count for the hash core.
module sha256_msg_padder #(
  parameter int LEN_W = 14,
  parameter int N_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_err,
  output logic [N_W-1:0]   o_n_blocks,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_byte_ready,
  output logic             o_blk_valid,
  output logic [511:0]     o_blk,
  output logic             o_blk_last,
  input  logic             i_blk_ready
);

  typedef enum logic [1:0] {IDLE, ABSORB, PAD, EMIT} state_t;

  state_t             state, state_nxt;
  logic [511:0]       blk;
  logic [6:0]         ptr;
  logic [LEN_W-1:0]   rem;
  logic               pad80;
  logic               last;
  logic [63:0]        bitlen;
  logic               err;
  logic [N_W-1:0]     n_blocks;

  logic [LEN_W:0]     n_sum, n_calc;
  logic               n_over;
  logic               start_ok;
  logic               accept;
  logic [6:0]         ptr_acc;
  logic [LEN_W-1:0]   rem_acc;
  logic [8:0]         wr_lsb;
  logic [6:0]         pad_ptr;
  logic               pad_last;
  logic [511:0]       pad_blk;

  // One spare bit so that N up to 257 is representable and the overflow is visible.
  assign n_sum    = {1'b0, i_len} + (LEN_W+1)'(8);
  assign n_calc   = (n_sum >> 6) + (LEN_W+1)'(1);
  assign n_over   = n_calc > (LEN_W+1)'((1 << N_W) - 1);
  assign start_ok = (state == IDLE) && i_start && !n_over;

  assign o_byte_ready = (state == ABSORB) && (rem != '0) && !ptr[6];
  assign accept       = o_byte_ready && i_byte_valid;
  assign ptr_acc      = ptr + 7'(accept);
  assign rem_acc      = rem - LEN_W'(accept);
  assign wr_lsb       = {~ptr[5:0], 3'b000};

  // Pad step: optional 0x80 at ptr, zero the tail, then length if it still fits.
  always_comb begin
    pad_ptr  = pad80 ? ptr : ptr + 7'd1;
    pad_last = (pad_ptr <= 7'd56);
    pad_blk  = blk;
    for (int k = 0; k < 64; k++) begin
      if (7'(k) >= ptr)
        pad_blk[511-8*k -: 8] = (!pad80 && (7'(k) == ptr)) ? 8'h80 : 8'h00;
    end
    if (pad_last)
      pad_blk[63:0] = bitlen;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_ok) state_nxt = ABSORB;
      ABSORB: begin
        if (ptr_acc == 7'd64)      state_nxt = EMIT;
        else if (rem_acc == '0)    state_nxt = PAD;
      end
      PAD:    state_nxt = EMIT;
      EMIT: begin
        if (i_blk_ready) begin
          if (last)                state_nxt = IDLE;
          else if (rem != '0)      state_nxt = ABSORB;
          else                     state_nxt = PAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk      <= '0;
      ptr      <= '0;
      rem      <= '0;
      pad80    <= 1'b0;
      last     <= 1'b0;
      bitlen   <= '0;
      err      <= 1'b0;
      n_blocks <= '0;
    end else begin
      err <= (state == IDLE) && i_start && n_over;
      case (state)
        IDLE: begin
          if (start_ok) begin
            n_blocks <= n_calc[N_W-1:0];
            ptr      <= '0;
            rem      <= i_len;
            pad80    <= 1'b0;
            last     <= 1'b0;
            blk      <= '0;
            bitlen   <= {{(61-LEN_W){1'b0}}, i_len, 3'b000};
          end
        end
        ABSORB: begin
          if (accept) blk[wr_lsb +: 8] <= i_byte;
          ptr  <= ptr_acc;
          rem  <= rem_acc;
          last <= 1'b0;
        end
        PAD: begin
          blk   <= pad_blk;
          pad80 <= 1'b1;
          ptr   <= pad_ptr;
          last  <= pad_last;
        end
        EMIT: begin
          if (i_blk_ready) begin
            blk <= '0;
            ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_err       = err;
  assign o_n_blocks  = n_blocks;
  assign o_blk_valid = (state == EMIT);
  assign o_blk       = blk;
  assign o_blk_last  = last && (state == EMIT);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: expected blocks are queued when a
// message is issued and popped by a monitor at every block handshake.
module tb_sha256_msg_padder;

  localparam int LEN_W = 14;
  localparam int N_W   = 8;

  typedef struct packed {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             o_busy;
  logic             o_err;
  logic [N_W-1:0]   o_n_blocks;
  logic             i_byte_valid;
  logic [7:0]       i_byte;
  logic             o_byte_ready;
  logic             o_blk_valid;
  logic [511:0]     o_blk;
  logic             o_blk_last;
  logic             i_blk_ready;

  int   vecs;
  int   fails;
  exp_t q[$];
  exp_t mon_e;
  exp_t tmp_e;
  logic [511:0] held;

  sha256_msg_padder #(.LEN_W(LEN_W), .N_W(N_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_n_blocks   (o_n_blocks),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_blk_valid  (o_blk_valid),
    .o_blk        (o_blk),
    .o_blk_last   (o_blk_last),
    .i_blk_ready  (i_blk_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] msg_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Reference: lay out the whole padded message byte by byte, then slice block b.
  function automatic exp_t model_blk(input int len, input int b);
    exp_t r;
    int n, idx;
    logic [63:0] bl;
    logic [7:0] v;
    n = (len + 8) / 64 + 1;
    bl = 64'(len) * 64'd8;
    r.blk = '0;
    for (int k = 0; k < 64; k++) begin
      idx = b * 64 + k;
      if (idx < len)              v = msg_byte(idx);
      else if (idx == len)        v = 8'h80;
      else if (idx >= n * 64 - 8) v = bl[8 * (n * 64 - 1 - idx) +: 8];
      else                        v = 8'h00;
      r.blk[511 - 8 * k -: 8] = v;
    end
    r.last = (b == n - 1);
    return r;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [511:0] b, input logic l);
    tmp_e.blk  = b;
    tmp_e.last = l;
    q.push_back(tmp_e);
  endtask

  task automatic start(input int len);
    i_len   = LEN_W'(len);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    int cnt;
    i_byte       = b;
    i_byte_valid = 1'b1;
    cnt          = 0;
    @(negedge clk);
    while (!o_byte_ready && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 300) begin
      vecs++;
      fails++;
      $display("FAIL byte_accept_timeout: got no ready expected ready within 300 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic feed_msg(input int len);
    for (int i = 0; i < len; i++) feed_byte(msg_byte(i));
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int cnt;
    cnt = 0;
    while ((o_busy || q.size() != 0) && cnt < 600) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(nm, 512'(cnt >= 600), 512'(0));
  endtask

  task automatic check_all_zero();
    check("rst_busy",       512'(o_busy),       512'(0));
    check("rst_err",        512'(o_err),        512'(0));
    check("rst_n_blocks",   512'(o_n_blocks),   512'(0));
    check("rst_byte_ready", 512'(o_byte_ready), 512'(0));
    check("rst_blk_valid",  512'(o_blk_valid),  512'(0));
    check("rst_blk",        o_blk,              512'(0));
    check("rst_blk_last",   512'(o_blk_last),   512'(0));
  endtask

  initial begin
    vecs = 0;
    fails = 0;
    clk = 1'b0;
    rst = 1'b1;
    i_start = 1'b0;
    i_len = '0;
    i_byte_valid = 1'b0;
    i_byte = '0;
    i_blk_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (o_blk_valid && i_blk_ready) begin
          if (q.size() == 0) begin
            vecs++;
            fails++;
            $display("FAIL unexpected_block: got %0h expected none", o_blk);
          end else begin
            mon_e = q.pop_front();
            check("blk", o_blk, mon_e.blk);
            check("blk_last", 512'(o_blk_last), 512'(mon_e.last));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_all_zero();
    rst = 1'b0;

    // "abc"
    push({32'h61626380, 416'h0, 64'h18}, 1'b1);
    start(3);
    check("abc_n", 512'(o_n_blocks), 512'(1));
    check("abc_busy", 512'(o_busy), 512'(1));
    feed_byte(8'h61); feed_byte(8'h62); feed_byte(8'h63);
    i_byte_valid = 1'b0;
    wait_idle("abc_drain");

    // empty message
    push({8'h80, 504'h0}, 1'b1);
    start(0);
    check("len0_n", 512'(o_n_blocks), 512'(1));
    check("len0_valid_t0", 512'(o_blk_valid), 512'(0));
    @(posedge clk); #1;
    check("len0_valid_t1", 512'(o_blk_valid), 512'(0));
    @(posedge clk); #1;
    check("len0_valid_t2", 512'(o_blk_valid), 512'(1));
    wait_idle("len0_drain");

    // 55 bytes: padding and length just fit
    tmp_e = model_blk(55, 0);
    q.push_back(tmp_e);
    start(55);
    check("len55_n", 512'(o_n_blocks), 512'(1));
    feed_msg(55);
    check("len55_lat1", 512'(o_blk_valid), 512'(0));
    @(posedge clk); #1;
    check("len55_lat2", 512'(o_blk_valid), 512'(1));
    wait_idle("len55_drain");

    // 56 bytes: length spills into a second block
    tmp_e = model_blk(56, 0);
    q.push_back(tmp_e);
    push({448'h0, 64'h1c0}, 1'b1);
    start(56);
    check("len56_n", 512'(o_n_blocks), 512'(2));
    feed_msg(56);
    wait_idle("len56_drain");

    // 64 bytes with downstream back-pressure
    tmp_e = model_blk(64, 0);
    q.push_back(tmp_e);
    push({8'h80, 440'h0, 64'h200}, 1'b1);
    i_blk_ready = 1'b0;
    start(64);
    check("len64_n", 512'(o_n_blocks), 512'(2));
    feed_msg(64);
    check("len64_full_valid", 512'(o_blk_valid), 512'(1));
    check("len64_blk0_last", 512'(o_blk_last), 512'(0));
    held = o_blk;
    i_byte = 8'hAA;
    i_byte_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_blk", o_blk, held);
      check("hold_no_ready", 512'(o_byte_ready), 512'(0));
    end
    i_byte_valid = 1'b0;
    i_blk_ready = 1'b1;
    wait_idle("len64_drain");

    // over-length start is rejected
    start(16312);
    check("err_pulse", 512'(o_err), 512'(1));
    check("err_busy", 512'(o_busy), 512'(0));
    check("err_n_kept", 512'(o_n_blocks), 512'(2));
    @(posedge clk); #1;
    check("err_one_cycle", 512'(o_err), 512'(0));

    // maximum length: 255 blocks
    for (int b = 0; b < 255; b++) begin
      tmp_e = model_blk(16311, b);
      q.push_back(tmp_e);
    end
    start(16311);
    check("max_n", 512'(o_n_blocks), 512'(255));
    check("max_no_err", 512'(o_err), 512'(0));
    feed_msg(16311);
    wait_idle("max_drain");

    // reset mid-absorb abandons the message
    start(100);
    check("len100_n", 512'(o_n_blocks), 512'(2));
    feed_msg(10);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero();
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 512'(o_busy), 512'(0));

    push({32'h61626380, 416'h0, 64'h18}, 1'b1);
    start(3);
    check("abc2_n", 512'(o_n_blocks), 512'(1));
    feed_byte(8'h61); feed_byte(8'h62); feed_byte(8'h63);
    i_byte_valid = 1'b0;
    wait_idle("abc2_drain");

    check("queue_empty", 512'(q.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
